// File: rtl/arb_pkg.sv
// Shared types and defaults for the memory port arbiter.
//   state_t : transaction phase (IDLE, ISSUE, WAIT, DONE)
//   owner_t : requester that holds the current grant
//   op_t    : bus operation of the current transaction
package arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/arb_timer.sv
// Watchdog counter for bus WAIT cycles.
//   clk, nrst : clock, asynchronous active-low reset
//   clr       : return the count to zero
//   en        : count one busy cycle
//   expired   : this enabled cycle is busy cycle number TIMEOUT
module arb_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flag while the last allowed busy cycle is being counted, so the FSM
  // leaves WAIT on exactly the TIMEOUT-th consecutive busy sample.
  assign expired = en && (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus port between instruction fetch and load/store.
// Each transaction runs IDLE -> ISSUE (one-cycle strobe) -> WAIT -> DONE
// (one-cycle ready to the owner); a watchdog aborts WAIT after TIMEOUT
// busy cycles and reports err with zero data.
//   Fetch side : i_req, i_addr -> i_ready, i_data
//   LSU side   : d_read, d_write, d_addr, d_wdata -> d_ready, d_data
//   Status     : err (pulses together with the ready of an aborted access)
//   Bus side   : bus_read, bus_write, bus_addr, bus_wdata <- bus_rdata, bus_busy
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_data,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_data,
  output logic              err,
  output logic              bus_read,
  output logic              bus_write,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_busy
);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  op_t               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              last_d_q, last_d_d;

  logic d_pend;
  logic pick_d;
  logic tmr_clr;
  logic tmr_en;
  logic tmr_expired;

  assign d_pend = d_read || d_write;
  // On contention the data side wins unless it also won the previous grant.
  assign pick_d = d_pend && (!i_req || !last_d_q);

  arb_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .nrst   (nrst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    last_d_d = last_d_q;
    tmr_clr  = 1'b1;
    tmr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req || d_pend) begin
          owner_d = pick_d ? OWN_D : OWN_I;
          op_d    = (pick_d && d_write) ? OP_WR : OP_RD;
          addr_d  = pick_d ? d_addr : i_addr;
          wdata_d = (pick_d && d_write) ? d_wdata : '0;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        tmr_clr = 1'b0;
        if (!bus_busy) begin
          // Stores report zero data, so only reads keep the bus word.
          rdata_d = (op_q == OP_RD) ? bus_rdata : '0;
          state_d = DONE;
        end else begin
          tmr_en = 1'b1;
          if (tmr_expired) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // Requests are not looked at here; a held request re-arbitrates
        // from IDLE on the next cycle.
        last_d_d = (owner_q == OWN_D);
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_I;
      op_q     <= OP_RD;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      last_d_q <= last_d_d;
    end
  end

  // Outputs decode the state register directly, so an asynchronous reset
  // drops strobes and ready pulses without waiting for a clock edge.
  assign bus_read  = (state_q == ISSUE) && (op_q == OP_RD);
  assign bus_write = (state_q == ISSUE) && (op_q == OP_WR);
  assign bus_addr  = (state_q != IDLE) ? addr_q : '0;
  assign bus_wdata = (state_q != IDLE) ? wdata_q : '0;
  assign i_ready   = (state_q == DONE) && (owner_q == OWN_I);
  assign d_ready   = (state_q == DONE) && (owner_q == OWN_D);
  assign i_data    = i_ready ? rdata_q : '0;
  assign d_data    = d_ready ? rdata_q : '0;
  assign err       = (state_q == DONE) && err_q;

endmodule
